// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and framing constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter producing a one-cycle bit_done strobe
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic bit_done
);

    localparam int W = $clog2(CLKS_PER_BIT + 1);

    logic [W-1:0] cnt;

    assign bit_done = enable && (cnt == W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || restart)
            cnt <= '0;
        else if (enable)
            cnt <= bit_done ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit async serial transmitter, start/8 data LSB first/stop; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       data_out,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] idx, idx_n;
    logic       data_n;
    logic       restart;
    logic       bit_done;
`ifdef UART_TX_PARITY_EN
    logic       par, par_n;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .enable  (state != IDLE),
        .bit_done(bit_done)
    );

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        restart = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: if (start) begin
                state_n = START;
                shift_n = data_in;
                idx_n   = 3'd0;
                restart = 1'b1;
`ifdef UART_TX_PARITY_EN
                par_n   = ^data_in;
`endif
            end
            START: if (bit_done) state_n = DATA;
            DATA: if (bit_done) begin
                shift_n = shift >> 1;
                idx_n   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (idx == LAST_BIT) state_n = PARITY;
`else
                if (idx == LAST_BIT) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_n = STOP;
`endif
            STOP: if (bit_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // line level is derived from the next state so the output register leads nothing combinationally
        data_n = (state_n == START) ? ~IDLE_LEVEL : (state_n == DATA) ? shift_n[0] : IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
        if (state_n == PARITY) data_n = par_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            idx      <= '0;
            data_out <= IDLE_LEVEL;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            idx      <= idx_n;
            data_out <= data_n;
            busy     <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at CLKS_PER_BIT=1 and 4
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F4C = 11'h698, FA5 = 11'h54A, FFF = 11'h5FE, F3C = 11'h478;
`else
    localparam int NB = 10;
    localparam logic [10:0] F4C = 11'h298, FA5 = 11'h34A, FFF = 11'h3FE, F3C = 11'h278;
`endif

    typedef struct {
        logic [10:0] frame;
        bit          abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, s1, s4, o1, b1, o4, b4;
    logic [7:0] d1, d4;
    exp_t       q1[$], q4[$];
    bit         cap1[$], cap4[$];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .data_in(d1), .data_out(o1), .busy(b1)
    );
    uart_tx #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .data_in(d4), .data_out(o4), .busy(b4)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    task automatic judge(input string n, input int c, input bit cap[$], input exp_t e);
        logic [10:0] got = '0;
        logic [10:0] m;
        int glitch = 0;
        int nb = (cap.size() + c - 1) / c;
        for (int i = 0; i < cap.size(); i++) begin
            if (i % c == 0) begin
                if (i / c < 11) got[i/c] = cap[i];
            end else if (cap[i] != cap[i - i % c]) glitch++;
        end
        if (e.abort) begin
            m = (11'd1 << nb) - 11'd1;
            check({n, " abort short"}, 32'(cap.size() < NB * c), 1);
            check({n, " abort prefix"}, got & m, e.frame & m);
        end else begin
            check({n, " length"}, cap.size(), NB * c);
            check({n, " frame"}, got, e.frame);
        end
        check({n, " glitch"}, glitch, 0);
    endtask

    always @(negedge clk) begin
        if (b1) cap1.push_back(o1);
        else if (cap1.size() != 0) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1 unexpected frame: %0d samples, required none", cap1.size());
            end else judge("u1", 1, cap1, q1.pop_front());
            cap1.delete();
        end
    end

    always @(negedge clk) begin
        if (b4) cap4.push_back(o4);
        else if (cap4.size() != 0) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL u4 unexpected frame: %0d samples, required none", cap4.size());
            end else judge("u4", 4, cap4, q4.pop_front());
            cap4.delete();
        end
    end

    task automatic send(input bit w4, input logic [7:0] d, input logic [10:0] f, input bit ab);
        @(negedge clk);
        if (w4) begin s4 = 1'b1; d4 = d; q4.push_back('{f, ab}); end
        else    begin s1 = 1'b1; d1 = d; q1.push_back('{f, ab}); end
        @(negedge clk);
        if (w4) begin
            s4 = 1'b0; d4 = ~d;
            check("u4 latency line", o4, 0);
            check("u4 latency busy", b4, 1);
        end else begin
            s1 = 1'b0; d1 = ~d;
            check("u1 latency line", o1, 0);
            check("u1 latency busy", b1, 1);
        end
    endtask

    task automatic wait_idle(input bit w4, input int budget);
        int n = 0;
        while ((w4 ? b4 : b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (w4 ? b4 : b1) begin
            checks++; errors++;
            $display("FAIL %s idle timeout: busy still 1 after %0d cycles, required 0", w4 ? "u4" : "u1", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; s1 = 1'b0; s4 = 1'b0; d1 = '0; d4 = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {o1, b1, o4, b4}, 4'b1010);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle outputs", {o1, b1, o4, b4}, 4'b1010);
        end
        send(0, 8'h4C, F4C, 0);
        wait_idle(0, 40);
        send(1, 8'hA5, FA5, 0);
        repeat (12) @(negedge clk);
        s4 = 1'b1; d4 = 8'hFF;
        @(negedge clk);
        s4 = 1'b0;
        wait_idle(1, 200);
        @(negedge clk);
        check("u4 rejected start idle", b4, 0);
        send(1, 8'hFF, FFF, 0);
        wait_idle(1, 200);
        @(negedge clk);
        s1 = 1'b1; d1 = 8'h4C; q1.push_back('{F4C, 1'b0});
        @(negedge clk);
        d1 = 8'h3C; q1.push_back('{F3C, 1'b0});
        check("u1 held-start busy", b1, 1);
        n = 0;
        while (b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("u1 gap busy", b1, 0);
        check("u1 gap line", o1, 1);
        @(negedge clk);
        check("u1 reaccept busy", b1, 1);
        check("u1 reaccept line", o1, 0);
        s1 = 1'b0;
        wait_idle(0, 40);
        send(1, 8'h3C, F3C, 1);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("u4 midframe reset line", o4, 1);
        check("u4 midframe reset busy", b4, 0);
        rst = 1'b0;
        send(1, 8'hA5, FA5, 0);
        wait_idle(1, 200);
        @(negedge clk);
        rst = 1'b1; s1 = 1'b1; d1 = 8'hFF;
        @(negedge clk);
        check("u1 rst beats start busy", b1, 0);
        check("u1 rst beats start line", o1, 1);
        rst = 1'b0; s1 = 1'b0;
        @(negedge clk);
        check("u1 no late accept", b1, 0);
        repeat (5) @(negedge clk);
        check("u1 queue drained", q1.size(), 0);
        check("u4 queue drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
